dx_latch_ctrl: RTL and testbench

- D/X pipeline register plus interlock control. It sits directly upstream of the bypass unit and produces the dx_ir, dx_pc, dx_a and dx_b that bypass and the ALU consume.
- Owns the load-use bubble insertion, branch flush of D/X, and the multdiv stall FSM, including the start pulse and the busy counter.
- Bypass is never asked to forward from an lw in X, and never sees a mul/div advance before its result is ready.

---
 rtl/dx_latch_ctrl.sv | 136 +++++++++++++
 tb/tb_dx_latch_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dx_latch_ctrl.sv
// D/X pipeline register with load-use bubble, branch flush and multdiv stall FSM.
// Feeds dx_ir/dx_pc/dx_a/dx_b to the bypass unit and the ALU.
module dx_latch_ctrl #(
  parameter int unsigned MD_MAX_CYCLES = 40,
  parameter int unsigned CNT_W         = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [31:0]      fd_ir,
  input  logic [31:0]      fd_pc,
  input  logic [31:0]      rf_a,
  input  logic [31:0]      rf_b,
  input  logic             branch_taken,
  input  logic             md_ready,
  output logic [31:0]      dx_ir,
  output logic [31:0]      dx_pc,
  output logic [31:0]      dx_a,
  output logic [31:0]      dx_b,
  output logic             stall_fd,
  output logic             fd_flush,
  output logic             xm_bubble,
  output logic             md_start,
  output logic             md_busy,
  output logic [CNT_W-1:0] md_cycles,
  output logic             md_timeout
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_BUSY  = 2'd2;

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_BEX  = 5'b10110;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;
  localparam logic [4:0] R_STAT  = 5'd30;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MD_MAX_CYCLES);

  logic [1:0] state;
  logic [4:0] fd_op, fd_rd, fd_rs, fd_rt;
  logic [4:0] dx_op, dx_rd;
  logic       dx_is_md;
  logic       uses_rs, uses_rt, uses_rd, uses_stat;
  logic       load_use;
  logic       md_hold;

  always_comb begin
    fd_op = fd_ir[31:27];
    fd_rd = fd_ir[26:22];
    fd_rs = fd_ir[21:17];
    fd_rt = fd_ir[16:12];
    dx_op = dx_ir[31:27];
    dx_rd = dx_ir[26:22];

    dx_is_md = (dx_op == OP_R) && ((dx_ir[6:2] == ALU_MUL) || (dx_ir[6:2] == ALU_DIV));

    // sw's rd is store data, forwarded later from W/M, so it never stalls here
    uses_rs   = fd_op inside {OP_R, OP_ADDI, OP_LW, OP_SW, OP_BNE, OP_BLT};
    uses_rt   = (fd_op == OP_R);
    uses_rd   = fd_op inside {OP_BNE, OP_BLT, OP_JR};
    uses_stat = (fd_op == OP_BEX);

    load_use = (dx_op == OP_LW) && (dx_rd != '0) &&
               ((uses_rs   && (fd_rs == dx_rd)) ||
                (uses_rt   && (fd_rt == dx_rd)) ||
                (uses_rd   && (fd_rd == dx_rd)) ||
                (uses_stat && (dx_rd == R_STAT)));

    md_hold = (state == ST_START) ||
              ((state == ST_BUSY) && !md_ready) ||
              ((state == ST_IDLE) && dx_is_md);

    stall_fd  = md_hold || (!branch_taken && load_use);
    fd_flush  = !md_hold && branch_taken;
    xm_bubble = md_hold;
    md_busy   = (state == ST_START) || (state == ST_BUSY);
    md_start  = (state == ST_START);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      md_cycles  <= '0;
      md_timeout <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (dx_is_md) state <= ST_START;
        ST_START: begin
          state     <= ST_BUSY;
          md_cycles <= '0;
        end
        ST_BUSY: begin
          if (md_ready) begin
            state <= ST_IDLE;
          end else if (md_cycles < CNT_MAX) begin
            md_cycles <= md_cycles + CNT_W'(1);
            if (md_cycles == CNT_MAX - CNT_W'(1)) md_timeout <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dx_ir <= '0;
      dx_pc <= '0;
      dx_a  <= '0;
      dx_b  <= '0;
    end else if (md_hold) begin
      dx_ir <= dx_ir;
      dx_pc <= dx_pc;
      dx_a  <= dx_a;
      dx_b  <= dx_b;
    end else if (branch_taken || load_use) begin
      dx_ir <= '0;
      dx_pc <= '0;
      dx_a  <= '0;
      dx_b  <= '0;
    end else begin
      dx_ir <= fd_ir;
      dx_pc <= fd_pc;
      dx_a  <= rf_a;
      dx_b  <= rf_b;
    end
  end

endmodule

// File: tb/tb_dx_latch_ctrl.sv
// Bench for dx_latch_ctrl: directed interlock scenarios, then random traffic,
// all compared against a register-read-set / occupancy-age reference model.
module tb_dx_latch_ctrl;

  localparam int unsigned MAXC = 40;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] fd_ir, fd_pc, rf_a, rf_b;
  logic        branch_taken, md_ready;
  logic [31:0] dx_ir, dx_pc, dx_a, dx_b;
  logic        stall_fd, fd_flush, xm_bubble, md_start, md_busy, md_timeout;
  logic [5:0]  md_cycles;

  dx_latch_ctrl #(.MD_MAX_CYCLES(MAXC), .CNT_W(6)) dut (
    .clock(clock), .reset_n(reset_n),
    .fd_ir(fd_ir), .fd_pc(fd_pc), .rf_a(rf_a), .rf_b(rf_b),
    .branch_taken(branch_taken), .md_ready(md_ready),
    .dx_ir(dx_ir), .dx_pc(dx_pc), .dx_a(dx_a), .dx_b(dx_b),
    .stall_fd(stall_fd), .fd_flush(fd_flush), .xm_bubble(xm_bubble),
    .md_start(md_start), .md_busy(md_busy), .md_cycles(md_cycles),
    .md_timeout(md_timeout)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: D/X contents, how many cycles the current D/X instruction
  // has sat there, and the sticky timeout.
  logic [31:0] m_ir, m_pc, m_a, m_b;
  int unsigned m_age;
  logic        m_to;
  logic        s_hold, s_lu;
  int          starts;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rd, rs, rt, alu);
    return {5'b00000, rd, rs, rt, 5'b00000, alu, 2'b00};
  endfunction

  function automatic logic [31:0] itype(input logic [4:0] op, rd, rs, input logic [16:0] imm);
    return {op, rd, rs, imm};
  endfunction

  // Set of architectural registers the instruction needs from the regfile
  // before X (sw's data register excluded; it is forwarded later).
  function automatic logic [31:0] reads(input logic [31:0] ir);
    logic [31:0] m;
    logic [31:0] one;
    m = '0;
    one = 32'd1;
    case (ir[31:27])
      5'b00000: m = (one << ir[21:17]) | (one << ir[16:12]);
      5'b00101, 5'b01000, 5'b00111: m = one << ir[21:17];
      5'b00010, 5'b00110: m = (one << ir[21:17]) | (one << ir[26:22]);
      5'b00100: m = one << ir[26:22];
      5'b10110: m[30] = 1'b1;
      default: m = '0;
    endcase
    m[0] = 1'b0;
    return m;
  endfunction

  function automatic logic is_md(input logic [31:0] ir);
    return (ir[31:27] == 5'b00000) && ((ir[6:2] == 5'b00110) || (ir[6:2] == 5'b00111));
  endfunction

  function automatic logic [4:0] pick_reg();
    int unsigned r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 5'd30 : 5'(r);
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [4:0] rd, rs, rt;
    int unsigned k;
    rd = pick_reg(); rs = pick_reg(); rt = pick_reg();
    k = $urandom_range(0, 11);
    case (k)
      0:  return rtype(rd, rs, rt, 5'($urandom_range(0, 5)));
      1:  return rtype(rd, rs, rt, 5'b00110);
      2:  return rtype(rd, rs, rt, 5'b00111);
      3:  return itype(5'b00101, rd, rs, 17'($urandom));
      4:  return itype(5'b01000, rd, rs, 17'($urandom));
      5:  return itype(5'b00111, rd, rs, 17'($urandom));
      6:  return itype(5'b00010, rd, rs, 17'($urandom));
      7:  return itype(5'b00110, rd, rs, 17'($urandom));
      8:  return itype(5'b00100, rd, 5'd0, 17'd0);
      9:  return itype(5'b10110, 5'd0, 5'd0, 17'($urandom));
      10: return itype(5'b00001, 5'd0, 5'd0, 17'($urandom));
      default: return $urandom;
    endcase
  endfunction

  task automatic model_reset();
    m_ir = '0; m_pc = '0; m_a = '0; m_b = '0;
    m_age = 0; m_to = 1'b0;
  endtask

  // Compare every output mid-cycle against the model's prediction.
  task automatic sample();
    logic md;
    logic [31:0] rset;
    int unsigned cyc;
    @(negedge clock);
    md   = is_md(m_ir);
    rset = reads(fd_ir);
    s_hold = md && !((m_age >= 2) && md_ready);
    s_lu   = (m_ir[31:27] == 5'b01000) && (m_ir[26:22] != 5'd0) && rset[m_ir[26:22]];
    check("dx_ir", dx_ir, m_ir);
    check("dx_pc", dx_pc, m_pc);
    check("dx_a", dx_a, m_a);
    check("dx_b", dx_b, m_b);
    check("stall_fd", 32'(stall_fd), 32'(s_hold || (!branch_taken && s_lu)));
    check("fd_flush", 32'(fd_flush), 32'(!s_hold && branch_taken));
    check("xm_bubble", 32'(xm_bubble), 32'(s_hold));
    check("md_start", 32'(md_start), 32'(md && (m_age == 1)));
    check("md_busy", 32'(md_busy), 32'(md && (m_age >= 1)));
    check("md_timeout", 32'(md_timeout), 32'(m_to));
    if (md && (m_age >= 2)) begin
      cyc = m_age - 2;
      if (cyc > MAXC) cyc = MAXC;
      check("md_cycles", 32'(md_cycles), cyc);
    end
  endtask

  task automatic advance();
    @(posedge clock);
    if (s_hold) begin
      if (m_age >= MAXC + 1) m_to = 1'b1;
      m_age++;
    end else if (branch_taken || s_lu) begin
      m_ir = '0; m_pc = '0; m_a = '0; m_b = '0; m_age = 0;
    end else begin
      m_ir = fd_ir; m_pc = fd_pc; m_a = rf_a; m_b = rf_b; m_age = 0;
    end
    #1;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  // Asynchronous reset asserted mid-cycle, held across two edges.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check("rst_dx_ir", dx_ir, 32'd0);
    check("rst_dx_pc", dx_pc, 32'd0);
    check("rst_dx_a", dx_a, 32'd0);
    check("rst_dx_b", dx_b, 32'd0);
    check("rst_ctrl", {26'd0, stall_fd, fd_flush, xm_bubble, md_start, md_busy, md_timeout}, 32'd0);
    check("rst_md_cycles", 32'(md_cycles), 32'd0);
    repeat (2) @(posedge clock);
    #1;
    check("rst_hold_dx_ir", dx_ir, 32'd0);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b1;
    fd_ir = 32'h2842_0005; fd_pc = 32'h0000_0010;
    rf_a = 32'h1111_1111; rf_b = 32'h2222_2222;
    branch_taken = 1'b0; md_ready = 1'b0;
    #2;
    do_reset();

    step();
    check("first_capture_ir", dx_ir, 32'h2842_0005);
    check("first_capture_pc", dx_pc, 32'h0000_0010);

    // lw r3,0(r1) then add r4,r3,r2: one bubble
    fd_ir = itype(5'b01000, 5'd3, 5'd1, 17'd0); fd_pc = 32'h11;
    step();
    fd_ir = rtype(5'd4, 5'd3, 5'd2, 5'd0); fd_pc = 32'h12;
    sample();
    check("lu_stall", 32'(stall_fd), 32'd1);
    advance();
    check("lu_bubble", dx_ir, 32'd0);
    step();
    check("lu_after", dx_ir, rtype(5'd4, 5'd3, 5'd2, 5'd0));

    // lw r3 then sw r3,0(r5): data-only match, no stall
    fd_ir = itype(5'b01000, 5'd3, 5'd1, 17'd0);
    step();
    fd_ir = itype(5'b00111, 5'd3, 5'd5, 17'd0);
    sample();
    check("sw_nostall", 32'(stall_fd), 32'd0);
    advance();
    check("sw_capture", dx_ir, itype(5'b00111, 5'd3, 5'd5, 17'd0));

    // flush beats load-use
    fd_ir = itype(5'b01000, 5'd3, 5'd1, 17'd0);
    step();
    fd_ir = rtype(5'd4, 5'd3, 5'd2, 5'd0);
    branch_taken = 1'b1;
    sample();
    check("br_flush", 32'(fd_flush), 32'd1);
    check("br_nostall", 32'(stall_fd), 32'd0);
    advance();
    branch_taken = 1'b0;
    check("br_nop", dx_ir, 32'd0);

    // mul r5,r6,r7 with md_ready after 16 BUSY cycles
    fd_ir = rtype(5'd5, 5'd6, 5'd7, 5'b00110);
    step();
    fd_ir = 32'h2842_0005;
    starts = 0;
    repeat (18) begin
      sample();
      starts += int'(md_start);
      check("md_stall", {30'd0, stall_fd, xm_bubble}, 32'd3);
      advance();
    end
    md_ready = 1'b1;
    sample();
    check("md_release_cycles", 32'(md_cycles), 32'd16);
    check("md_release_stall", 32'(stall_fd), 32'd0);
    check("md_one_start", starts, 32'd1);
    advance();
    md_ready = 1'b0;
    check("md_advanced", dx_ir, 32'h2842_0005);

    // back-to-back mul then div
    fd_ir = rtype(5'd5, 5'd6, 5'd7, 5'b00110);
    step();
    fd_ir = rtype(5'd8, 5'd5, 5'd6, 5'b00111);
    repeat (5) step();
    md_ready = 1'b1;
    step();
    md_ready = 1'b0;
    check("b2b_div_in", dx_ir, rtype(5'd8, 5'd5, 5'd6, 5'b00111));
    fd_ir = 32'd0;
    sample();
    check("b2b_idle_nostart", 32'(md_start), 32'd0);
    advance();
    sample();
    check("b2b_restart", 32'(md_start), 32'd1);
    advance();
    md_ready = 1'b1;
    step();
    md_ready = 1'b0;

    // timeout saturation and stickiness
    do_reset();
    fd_ir = rtype(5'd5, 5'd6, 5'd7, 5'b00110);
    step();
    fd_ir = 32'd0;
    repeat (50) step();
    sample();
    check("to_sat", 32'(md_cycles), MAXC);
    check("to_flag", 32'(md_timeout), 32'd1);
    advance();
    md_ready = 1'b1;
    step();
    md_ready = 1'b0;
    repeat (3) step();
    check("to_sticky", 32'(md_timeout), 32'd1);
    do_reset();

    // reset during BUSY abandons the operation
    fd_ir = rtype(5'd5, 5'd6, 5'd7, 5'b00110);
    step();
    fd_ir = 32'd0;
    repeat (7) step();
    check("midbusy_busy", 32'(md_busy), 32'd1);
    do_reset();
    starts = 0;
    repeat (6) begin
      sample();
      starts += int'(md_start);
      advance();
    end
    check("midbusy_nostart", starts, 32'd0);

    // random traffic
    repeat (400) begin
      fd_ir = gen_instr();
      fd_pc = $urandom;
      rf_a = $urandom;
      rf_b = $urandom;
      branch_taken = ($urandom_range(0, 9) == 0);
      md_ready = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
